// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared constants and helpers for the matrix-multiplication datapath
package mm_pkg;

    // Elastic stage occupancy states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int DEFAULT_DATA_WIDTH = 18;

    // Bits needed to hold an occupancy of 0..2*depth
    function automatic int cnt_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// rtl/elastic_stage.sv - one fully registered valid/ready stage with a skid slot
module elastic_stage
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  up_valid,
    output logic                  up_ready,
    output logic [DATA_WIDTH-1:0] down_data,
    output logic                  down_valid,
    input  logic                  down_ready
);

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  full_q;
    logic                  accept;

    // Ready is held as a registered "full" flag so it clears to 0 on reset
    // and ready reads 1 straight out of reset without a combinational path.
    assign up_ready   = ~full_q;
    assign accept     = up_valid & ~full_q;
    assign down_valid = (state != ST_EMPTY);
    assign down_data  = main_q;

    // Occupancy FSM: main register feeds downstream, skid catches the word
    // that arrives in the cycle the downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
            full_q <= 1'b0;
        end else if (flush) begin
            state  <= ST_EMPTY;
            full_q <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state  <= ST_ONE;
                        main_q <= up_data;
                    end
                end
                ST_ONE: begin
                    if (accept && down_ready) begin
                        main_q <= up_data;
                    end else if (accept) begin
                        state  <= ST_TWO;
                        skid_q <= up_data;
                        full_q <= 1'b1;
                    end else if (down_ready) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (down_ready) begin
                        state  <= ST_ONE;
                        main_q <= skid_q;
                        full_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_EMPTY;
                    full_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// rtl/elastic_pipe.sv - DEPTH-stage elastic retiming pipe with flush and occupancy count
module elastic_pipe
    import mm_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH      = 2,
    localparam int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      count
);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("elastic_pipe: DEPTH must be in 1..16");
    end

    // Handshake chain: index k is the upstream side of stage k
    logic [DATA_WIDTH-1:0] data_c [0:DEPTH];
    logic [DEPTH:0]        valid_c;
    logic [DEPTH:0]        ready_c;
    logic                  in_xfer;
    logic                  out_xfer;

    assign data_c[0]      = in_data;
    assign valid_c[0]     = in_valid & ~flush;
    assign ready_c[DEPTH] = out_ready;

    // Flush blocks intake in its own cycle so the cleared pipe starts empty
    assign in_ready  = ready_c[0] & ~flush;
    assign out_data  = data_c[DEPTH];
    assign out_valid = valid_c[DEPTH];

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        elastic_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_data    (data_c[k]),
            .up_valid   (valid_c[k]),
            .up_ready   (ready_c[k]),
            .down_data  (data_c[k+1]),
            .down_valid (valid_c[k+1]),
            .down_ready (ready_c[k+1])
        );
    end

    // Occupancy tracks transfers at both ends; a word leaving in the flush
    // cycle is already delivered, so flush simply zeroes the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CNT_W'(1);
        end else if (out_xfer && !in_xfer) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// tb/tb_elastic_pipe.sv - self-checking bench for elastic_pipe at DEPTH 1..4
`timescale 1ns/1ps
module tb_elastic_pipe;
    import mm_pkg::*;

    localparam int DW  = 18;
    localparam int CW1 = cnt_width(1);
    localparam int CW2 = cnt_width(2);
    localparam int CW3 = cnt_width(3);
    localparam int CW4 = cnt_width(4);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic           p1_flush = 0, p1_in_valid = 0, p1_in_ready, p1_out_valid, p1_out_ready = 0;
    logic [DW-1:0]  p1_in_data = '0, p1_out_data;
    logic [CW1-1:0] p1_count;
    logic           p2_flush = 0, p2_in_valid = 0, p2_in_ready, p2_out_valid, p2_out_ready = 0;
    logic [DW-1:0]  p2_in_data = '0, p2_out_data;
    logic [CW2-1:0] p2_count;
    logic           p3_flush = 0, p3_in_valid = 0, p3_in_ready, p3_out_valid, p3_out_ready = 0;
    logic [DW-1:0]  p3_in_data = '0, p3_out_data;
    logic [CW3-1:0] p3_count;
    logic           p4_flush = 0, p4_in_valid = 0, p4_in_ready, p4_out_valid, p4_out_ready = 0;
    logic [DW-1:0]  p4_in_data = '0, p4_out_data;
    logic [CW4-1:0] p4_count;

    elastic_pipe #(.DATA_WIDTH(DW), .DEPTH(1)) u_p1 (
        .clk(clk), .rst(rst), .flush(p1_flush), .in_data(p1_in_data), .in_valid(p1_in_valid),
        .in_ready(p1_in_ready), .out_data(p1_out_data), .out_valid(p1_out_valid),
        .out_ready(p1_out_ready), .count(p1_count));
    elastic_pipe #(.DATA_WIDTH(DW), .DEPTH(2)) u_p2 (
        .clk(clk), .rst(rst), .flush(p2_flush), .in_data(p2_in_data), .in_valid(p2_in_valid),
        .in_ready(p2_in_ready), .out_data(p2_out_data), .out_valid(p2_out_valid),
        .out_ready(p2_out_ready), .count(p2_count));
    elastic_pipe #(.DATA_WIDTH(DW), .DEPTH(3)) u_p3 (
        .clk(clk), .rst(rst), .flush(p3_flush), .in_data(p3_in_data), .in_valid(p3_in_valid),
        .in_ready(p3_in_ready), .out_data(p3_out_data), .out_valid(p3_out_valid),
        .out_ready(p3_out_ready), .count(p3_count));
    elastic_pipe #(.DATA_WIDTH(DW), .DEPTH(4)) u_p4 (
        .clk(clk), .rst(rst), .flush(p4_flush), .in_data(p4_in_data), .in_valid(p4_in_valid),
        .in_ready(p4_in_ready), .out_data(p4_out_data), .out_valid(p4_out_valid),
        .out_ready(p4_out_ready), .count(p4_count));

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_w;

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (p2_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", p2_out_valid); end
        n_checks++; if (p2_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", p2_count); end
        rst = 1'b1;
        p2_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            p2_in_valid = 1'b1;
            p2_in_data  = DW'(i + 7);
        end
        @(negedge clk);
        p2_in_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        n_checks++; if (p2_out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_out_valid: got %b expected 0", p2_out_valid); end
        n_checks++; if (p2_count !== '0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", p2_count); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (p2_out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b expected 0", p2_out_valid); end
        n_checks++; if (p2_count !== '0) begin n_fail++; $display("FAIL release_count: got %0d expected 0", p2_count); end
        n_checks++; if (p2_in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", p2_in_ready); end
    endtask

    task automatic test_streaming();
        int first = -1;
        int got = 0;
        sb.delete();
        p3_out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            p3_in_valid = (i < 8);
            p3_in_data  = DW'(i + 1);
            #1;
            if (i < 8) begin
                n_checks++; if (p3_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready: cycle %0d got %b expected 1", i, p3_in_ready); end
            end
            if (i >= 3 && i <= 8) begin
                n_checks++; if (p3_count !== CW3'(3)) begin n_fail++; $display("FAIL stream_count: cycle %0d got %0d expected 3", i, p3_count); end
            end
            if (i >= 3 && i <= 10) begin
                n_checks++; if (p3_out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_gap: cycle %0d out_valid %b expected 1", i, p3_out_valid); end
            end
            if (p3_in_valid && p3_in_ready) sb.push_back(p3_in_data);
            if (p3_out_valid && p3_out_ready) begin
                if (first < 0) first = i;
                got++;
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL stream_extra: got %h expected no word", p3_out_data); end
                else begin
                    exp_w = sb.pop_front();
                    if (p3_out_data !== exp_w) begin n_fail++; $display("FAIL stream_data: got %h expected %h", p3_out_data, exp_w); end
                end
            end
        end
        p3_in_valid = 1'b0;
        n_checks++; if (first != 3) begin n_fail++; $display("FAIL stream_latency: first output cycle %0d expected 3", first); end
        n_checks++; if (got != 8) begin n_fail++; $display("FAIL stream_total: got %0d words expected 8", got); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int first = -1;
        int back = -1;
        int got = 0;
        sb.delete();
        p2_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            p2_in_valid = 1'b1;
            p2_in_data  = (i == 0) ? 18'h3FFFF : DW'(i);
            #1;
            if (p2_in_valid && p2_in_ready) begin sb.push_back(p2_in_data); acc++; end
        end
        @(negedge clk);
        p2_in_valid = 1'b0;
        #1;
        n_checks++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
        n_checks++; if (p2_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", p2_in_ready); end
        n_checks++; if (p2_count !== CW2'(4)) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", p2_count); end
        n_checks++; if (p2_out_valid !== 1'b1 || p2_out_data !== 18'h3FFFF) begin n_fail++; $display("FAIL bp_hold: got valid %b data %h expected 1 3ffff", p2_out_valid, p2_out_data); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            p2_out_ready = 1'b1;
            #1;
            if (first >= 0 && back < 0 && p2_in_ready === 1'b1) back = i;
            if (p2_out_valid && p2_out_ready) begin
                if (first < 0) first = i;
                got++;
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_extra: got %h expected no word", p2_out_data); end
                else begin
                    exp_w = sb.pop_front();
                    if (p2_out_data !== exp_w) begin n_fail++; $display("FAIL bp_data: got %h expected %h", p2_out_data, exp_w); end
                end
            end
        end
        p2_out_ready = 1'b0;
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL bp_drain: got %0d words expected 4", got); end
        n_checks++; if (back < 0 || back - first > 2) begin n_fail++; $display("FAIL bp_ready_back: cycles after first output %0d expected 1..2", back - first); end
    endtask

    task automatic test_random();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        sb.delete();
        while ((sent < 1000 || got < 1000) && cyc < 20000) begin
            @(negedge clk);
            p4_in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
            p4_in_data   = DW'($urandom);
            p4_out_ready = ($urandom_range(0, 1) == 1);
            #1;
            n_checks++; if (p4_count !== CW4'(sb.size())) begin n_fail++; $display("FAIL rand_count: cycle %0d got %0d expected %0d", cyc, p4_count, sb.size()); end
            if (p4_in_valid && p4_in_ready) begin sb.push_back(p4_in_data); sent++; end
            if (p4_out_valid && p4_out_ready) begin
                got++;
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL rand_extra: got %h expected no word", p4_out_data); end
                else begin
                    exp_w = sb.pop_front();
                    if (p4_out_data !== exp_w) begin n_fail++; $display("FAIL rand_data: got %h expected %h", p4_out_data, exp_w); end
                end
            end
            cyc++;
        end
        p4_in_valid  = 1'b0;
        p4_out_ready = 1'b0;
        n_checks++; if (got != 1000) begin n_fail++; $display("FAIL rand_total: got %0d words expected 1000", got); end
    endtask

    task automatic test_flush();
        int first = -1;
        int got = 0;
        sb.delete();
        p3_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            p3_in_valid = (sb.size() < 5);
            p3_in_data  = DW'(16'h0A00 + i);
            #1;
            if (p3_in_valid && p3_in_ready) sb.push_back(p3_in_data);
        end
        n_checks++; if (p3_count !== CW3'(5)) begin n_fail++; $display("FAIL flush_fill: got %0d expected 5", p3_count); end
        @(negedge clk);
        p3_flush     = 1'b1;
        p3_in_valid  = 1'b1;
        p3_in_data   = 18'h2AAAA;
        p3_out_ready = 1'b1;
        #1;
        n_checks++; if (p3_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", p3_in_ready); end
        n_checks++; if (p3_out_valid !== 1'b1 || p3_out_data !== sb[0]) begin n_fail++; $display("FAIL flush_deliver: got valid %b data %h expected 1 %h", p3_out_valid, p3_out_data, sb[0]); end
        sb.delete();
        @(negedge clk);
        p3_flush    = 1'b0;
        p3_in_valid = 1'b1;
        p3_in_data  = 18'h12345;
        #1;
        n_checks++; if (p3_count !== '0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", p3_count); end
        n_checks++; if (p3_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", p3_out_valid); end
        n_checks++; if (p3_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_reopen: got %b expected 1", p3_in_ready); end
        if (p3_in_valid && p3_in_ready) sb.push_back(p3_in_data);
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            p3_in_valid = 1'b0;
            #1;
            if (p3_out_valid && p3_out_ready) begin
                if (first < 0) first = i;
                got++;
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL flush_stale: got %h expected no word", p3_out_data); end
                else begin
                    exp_w = sb.pop_front();
                    if (p3_out_data !== exp_w) begin n_fail++; $display("FAIL flush_data: got %h expected %h", p3_out_data, exp_w); end
                end
            end
        end
        p3_out_ready = 1'b0;
        n_checks++; if (first != 3) begin n_fail++; $display("FAIL flush_latency: first output cycle %0d expected 3", first); end
        n_checks++; if (got != 1) begin n_fail++; $display("FAIL flush_alone: got %0d words expected 1", got); end
    endtask

    task automatic test_full_simul();
        int sent = 0;
        int got = 0;
        sb.delete();
        p1_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            p1_in_valid = 1'b1;
            p1_in_data  = DW'(16'h0100 + i);
            #1;
            if (p1_in_valid && p1_in_ready) begin sb.push_back(p1_in_data); sent++; end
        end
        @(negedge clk);
        p1_in_valid = 1'b0;
        #1;
        n_checks++; if (p1_count !== CW1'(2)) begin n_fail++; $display("FAIL simul_fill: got %0d expected 2", p1_count); end
        n_checks++; if (p1_in_ready !== 1'b0) begin n_fail++; $display("FAIL simul_in_ready: got %b expected 0", p1_in_ready); end
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            p1_out_ready = 1'b1;
            p1_in_valid  = (i < 10);
            p1_in_data   = DW'(16'h0200 + i);
            #1;
            n_checks++; if (p1_count > CW1'(2)) begin n_fail++; $display("FAIL simul_count: got %0d expected <= 2", p1_count); end
            if (i <= 10) begin
                n_checks++; if (p1_out_valid !== 1'b1) begin n_fail++; $display("FAIL simul_rate: cycle %0d out_valid %b expected 1", i, p1_out_valid); end
            end
            if (p1_in_valid && p1_in_ready) begin sb.push_back(p1_in_data); sent++; end
            if (p1_out_valid && p1_out_ready) begin
                got++;
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL simul_extra: got %h expected no word", p1_out_data); end
                else begin
                    exp_w = sb.pop_front();
                    if (p1_out_data !== exp_w) begin n_fail++; $display("FAIL simul_data: got %h expected %h", p1_out_data, exp_w); end
                end
            end
        end
        p1_in_valid  = 1'b0;
        p1_out_ready = 1'b0;
        n_checks++; if (got != sent || sb.size() != 0) begin n_fail++; $display("FAIL simul_loss: got %0d words expected %0d", got, sent); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_flush();
        test_full_simul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
